// File: rtl/uart_cmd_initiator.sv
// Host-side command initiator: sends one command byte through the uart
// transmit handshake, then gathers RESP_BYTES response bytes, ending with a
// done pulse or a timeout pulse if the responder goes quiet.
module uart_cmd_initiator #(
    parameter int unsigned RESP_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 120000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              cmd,
    input  logic                    uart_tx_ready,
    output logic [7:0]              uart_data_to_tx,
    output logic                    uart_tx_enable,
    input  logic                    uart_rx_ready,
    input  logic [7:0]              uart_data_from_rx,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [8*RESP_BYTES-1:0] resp_data,
    output logic [4:0]              resp_count
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    // TXWAIT is split into "wait for ready low" and "wait for ready high again".
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_TXLO,
        S_TXHI,
        S_RECV
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          accept;
    logic          capture;
    logic          load_cnt;
    logic          fin_done;
    logic          fin_tmo;

    assign busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the transmit strobe and datapath controls.
    always_comb begin
        state_nxt      = state;
        uart_tx_enable = 1'b0;
        accept         = 1'b0;
        capture        = 1'b0;
        load_cnt       = 1'b0;
        fin_done       = 1'b0;
        fin_tmo        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (uart_tx_ready) begin
                    uart_tx_enable = 1'b1;
                    state_nxt      = S_TXLO;
                end
            end
            S_TXLO: begin
                capture = uart_rx_ready;
                if (!uart_tx_ready) begin
                    state_nxt = S_TXHI;
                end
            end
            S_TXHI: begin
                capture = uart_rx_ready;
                if (uart_tx_ready) begin
                    load_cnt  = 1'b1;
                    state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                capture = uart_rx_ready;
                // A byte arriving on the expiry cycle takes priority.
                if (!uart_rx_ready && tmo_cnt == CW'(1)) begin
                    fin_tmo   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (capture && resp_count == 5'(RESP_BYTES - 1)) begin
            fin_done  = 1'b1;
            fin_tmo   = 1'b0;
            state_nxt = S_IDLE;
        end
    end

    // Command latch, response capture, timeout counter and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_data_to_tx <= '0;
            resp_data       <= '0;
            resp_count      <= '0;
            tmo_cnt         <= '0;
            done            <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            done    <= fin_done;
            timeout <= fin_tmo;
            if (accept) begin
                uart_data_to_tx <= cmd;
                resp_data       <= '0;
                resp_count      <= '0;
            end
            if (capture) begin
                for (int unsigned i = 0; i < RESP_BYTES; i++) begin
                    if (resp_count == 5'(i)) begin
                        resp_data[(RESP_BYTES-1-i)*8 +: 8] <= uart_data_from_rx;
                    end
                end
                resp_count <= resp_count + 5'd1;
            end
            if (capture || load_cnt) begin
                tmo_cnt <= CW'(TIMEOUT_CYCLES);
            end else if (state == S_RECV) begin
                tmo_cnt <= tmo_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed bench for uart_cmd_initiator with RESP_BYTES=4, TIMEOUT_CYCLES=100.
module tb_uart_cmd_initiator;

    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cmd;
    logic        uart_tx_ready;
    logic [7:0]  uart_data_to_tx;
    logic        uart_tx_enable;
    logic        uart_rx_ready;
    logic [7:0]  uart_data_from_rx;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] resp_data;
    logic [4:0]  resp_count;

    int checks = 0;
    int errors = 0;
    int tx_en_cnt = 0;
    int done_cnt = 0;
    int to_cnt = 0;
    int both_cnt = 0;

    uart_cmd_initiator #(.RESP_BYTES(4), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cmd(cmd),
        .uart_tx_ready(uart_tx_ready),
        .uart_data_to_tx(uart_data_to_tx),
        .uart_tx_enable(uart_tx_enable),
        .uart_rx_ready(uart_rx_ready),
        .uart_data_from_rx(uart_data_from_rx),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .resp_data(resp_data),
        .resp_count(resp_count)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle once inputs have settled.
    always @(negedge clk) begin
        #2;
        if (uart_tx_enable) tx_en_cnt++;
        if (done) done_cnt++;
        if (timeout) to_cnt++;
        if (done && timeout) both_cnt++;
    end

    typedef struct {
        logic [7:0]  cmd;
        int          n;
        logic [31:0] bytes;
        int          gap;
        logic [31:0] exp_data;
        logic [4:0]  exp_cnt;
        bit          exp_done;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send_start(input logic [7:0] c);
        start = 1'b1;
        cmd   = c;
        cyc();
        start = 1'b0;
    endtask

    // From SEND with tx_ready high: strobe, ready low for two cycles, ready high.
    task automatic do_tx();
        cyc();
        uart_tx_ready = 1'b0;
        cyc();
        cyc();
        uart_tx_ready = 1'b1;
        cyc();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        uart_rx_ready     = 1'b1;
        uart_data_from_rx = b;
        cyc();
        uart_rx_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        #1;
        chk({tag, "_data_to_tx"}, uart_data_to_tx, 0);
        chk({tag, "_tx_enable"}, uart_tx_enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_resp_count"}, resp_count, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int d0 = done_cnt;
        int t0 = to_cnt;
        int e0 = tx_en_cnt;
        int seen = -1;
        send_start(v.cmd);
        #1;
        chk("tx_en_latency", uart_tx_enable, 1);
        chk("tx_data", uart_data_to_tx, v.cmd);
        chk("busy_after_start", busy, 1);
        do_tx();
        for (int i = 0; i < v.n; i++) begin
            idle(v.gap - 1);
            rx_byte(v.bytes[(3 - i) * 8 +: 8]);
        end
        if (v.exp_done) begin
            chk("done_pulse", done, 1);
            chk("no_timeout", timeout, 0);
        end else begin
            for (int k = 1; k <= T + 5; k++) begin
                cyc();
                if (timeout) begin
                    seen = k;
                    break;
                end
            end
            chk("timeout_delay", seen, T);
            chk("no_done", done, 0);
        end
        chk("resp_data", resp_data, v.exp_data);
        chk("resp_count", resp_count, v.exp_cnt);
        chk("busy_end", busy, 0);
        cyc();
        chk("pulses_clear", {done, timeout}, 0);
        chk("resp_hold", resp_data, v.exp_data);
        chk("tx_en_count", tx_en_cnt - e0, 1);
        chk("done_count", done_cnt - d0, v.exp_done ? 1 : 0);
        chk("timeout_count", to_cnt - t0, v.exp_done ? 0 : 1);
    endtask

    initial begin
        vt[0] = '{8'hA5, 4, 32'h11223344, 1, 32'h11223344, 5'd4, 1'b1};
        vt[1] = '{8'h3C, 4, 32'hDEADBEEF, 3, 32'hDEADBEEF, 5'd4, 1'b1};
        vt[2] = '{8'h00, 2, 32'hAABBCCDD, 2, 32'hAABB0000, 5'd2, 1'b0};
        vt[3] = '{8'hFF, 0, 32'h00000000, 1, 32'h00000000, 5'd0, 1'b0};
        vt[4] = '{8'h5A, 4, 32'h01020304, T, 32'h01020304, 5'd4, 1'b1};
        vt[5] = '{8'h81, 1, 32'h7E000000, 5, 32'h7E000000, 5'd1, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        cmd = 8'h00;
        uart_tx_ready = 1'b1;
        uart_rx_ready = 1'b0;
        uart_data_from_rx = 8'h00;
        @(negedge clk);
        idle(3);
        rst = 1'b0;
        chk_all_zero("reset");

        // Reset beats a simultaneous start.
        rst = 1'b1;
        start = 1'b1;
        cmd = 8'h66;
        cyc();
        rst = 1'b0;
        start = 1'b0;
        chk_all_zero("rst_vs_start");

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Transmitter held busy for 50 cycles, then a loopback echo during TXWAIT.
        begin
            int e0;
            uart_tx_ready = 1'b0;
            e0 = tx_en_cnt;
            send_start(8'h42);
            idle(50);
            chk("no_tx_while_not_ready", tx_en_cnt - e0, 0);
            chk("busy_waiting", busy, 1);
            uart_tx_ready = 1'b1;
            #1;
            chk("tx_en_on_ready", uart_tx_enable, 1);
            cyc();
            uart_tx_ready = 1'b0;
            rx_byte(8'hE1);
            uart_tx_ready = 1'b1;
            cyc();
            rx_byte(8'h02);
            rx_byte(8'h03);
            rx_byte(8'h04);
            chk("echo_done", done, 1);
            chk("echo_resp", resp_data, 32'hE1020304);
            cyc();
            chk("single_tx_strobe", tx_en_cnt - e0, 1);
        end

        // Stray rx in IDLE and start pulses while busy.
        begin
            int d0;
            int e0;
            rx_byte(8'h99);
            rx_byte(8'h98);
            chk("idle_rx_ignored", resp_data, 32'hE1020304);
            chk("idle_rx_count", resp_count, 4);
            d0 = done_cnt;
            e0 = tx_en_cnt;
            send_start(8'h12);
            start = 1'b1;
            cmd = 8'h77;
            do_tx();
            rx_byte(8'hA1);
            rx_byte(8'hA2);
            rx_byte(8'hA3);
            chk("tx_data_stable", uart_data_to_tx, 8'h12);
            start = 1'b0;
            rx_byte(8'hA4);
            chk("busy_start_resp", resp_data, 32'hA1A2A3A4);
            rx_byte(8'h55);
            rx_byte(8'h56);
            cyc();
            chk("extra_rx_ignored", resp_data, 32'hA1A2A3A4);
            chk("extra_rx_count", resp_count, 4);
            chk("one_done", done_cnt - d0, 1);
            chk("one_tx", tx_en_cnt - e0, 1);
            chk("idle_after", busy, 0);
        end

        // Reset after the first byte aborts silently.
        begin
            int d0;
            int t0;
            d0 = done_cnt;
            t0 = to_cnt;
            send_start(8'hC3);
            do_tx();
            rx_byte(8'h10);
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            chk_all_zero("mid_reset");
            idle(T + 10);
            chk("reset_no_pulses", {done_cnt - d0, to_cnt - t0}, 0);
            run_vec(vt[0]);
        end

        chk("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
